lcd_code_feeder: RTL



---
 rtl/lcd_feed_pkg.sv | 18 +
 rtl/lcd_feed_if.sv | 23 ++
 rtl/lcd_feed_fifo.sv | 50 +++++
 rtl/lcd_code_feeder.sv | 107 ++++++++++
 4 files changed

// File: rtl/lcd_feed_pkg.sv
// Shared types and pacing constants for the LCD12864 code feeder.
package lcd_feed_pkg;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } feed_state_t;

  localparam int GROUP_LEN = 16;
  localparam int FRAME_LEN = 64;
  localparam int GROUP_GAP = 1;
  localparam int FRAME_GAP = 8;

  localparam logic [1:0] CODE_WHITE = 2'b00;
  localparam logic [1:0] CODE_BLACK = 2'b11;

endpackage

// File: rtl/lcd_feed_if.sv
// Code-in / LCD-out bundle between classifier, feeder and LCD driver.
// Optional Underflow signal exists only when FEED_UNDERFLOW_FLAG_EN is defined.
interface lcd_feed_if #(parameter int DEPTH = 16);
  logic [1:0]              Code_In;
  logic                    Code_Valid;
  logic                    Code_Ready;
  logic [1:0]              Lcd_Data;
  logic                    Lcd_Valid;
  logic [$clog2(DEPTH):0]  Fifo_Level;
`ifdef FEED_UNDERFLOW_FLAG_EN
  logic                    Underflow;

  modport master (output Code_In, Code_Valid,
                  input  Code_Ready, Lcd_Data, Lcd_Valid, Fifo_Level, Underflow);
  modport slave  (input  Code_In, Code_Valid,
                  output Code_Ready, Lcd_Data, Lcd_Valid, Fifo_Level, Underflow);
`else
  modport master (output Code_In, Code_Valid,
                  input  Code_Ready, Lcd_Data, Lcd_Valid, Fifo_Level);
  modport slave  (input  Code_In, Code_Valid,
                  output Code_Ready, Lcd_Data, Lcd_Valid, Fifo_Level);
`endif
endinterface

// File: rtl/lcd_feed_fifo.sv
// Synchronous FIFO for 2-bit codes; no read bypass, read data is the head entry.
module lcd_feed_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic [WIDTH-1:0]        wdata,
  output logic [WIDTH-1:0]        rdata,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign level = count;
  assign rdata = mem[rd_ptr];
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !rd_en)      count <= count + 1'b1;
      else if (rd_en && !wr_en) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/lcd_code_feeder.sv
// Buffers segment codes and issues them to the LCD12864 driver with init/group/frame pacing.
// Optional sticky Underflow output enabled by FEED_UNDERFLOW_FLAG_EN.
module lcd_code_feeder
  import lcd_feed_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int INIT_IDLE = 7
) (
  input  logic       LcdFeed_clk,
  input  logic       LcdFeed_rst,
  lcd_feed_if.slave  feed
);
  localparam int IW = $clog2(INIT_IDLE + 1);

  feed_state_t       state;
  logic [IW-1:0]     idle_cnt;
  logic [5:0]        code_cnt;
  logic [5:0]        cnt_next;
  logic [3:0]        gap_cnt;
  logic [1:0]        lcd_data;
  logic              lcd_valid;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [1:0]        head;
  logic [$clog2(DEPTH):0] level;

  assign feed.Code_Ready = !full && !LcdFeed_rst;
  assign push            = feed.Code_Valid && feed.Code_Ready;
  assign pop             = (state == RUN) && !empty;
  assign cnt_next        = code_cnt + 6'd1;

  assign feed.Lcd_Data   = lcd_data;
  assign feed.Lcd_Valid  = lcd_valid;
  assign feed.Fifo_Level = level;

  lcd_feed_fifo #(.DEPTH(DEPTH), .WIDTH(2)) u_fifo (
    .clk   (LcdFeed_clk),
    .rst   (LcdFeed_rst),
    .push  (push),
    .pop   (pop),
    .wdata (feed.Code_In),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // Frame boundary takes priority so the 64th code gets only the long gap.
  always_ff @(posedge LcdFeed_clk) begin
    if (LcdFeed_rst) begin
      state     <= INIT;
      idle_cnt  <= '0;
      code_cnt  <= '0;
      gap_cnt   <= '0;
      lcd_data  <= CODE_WHITE;
      lcd_valid <= 1'b0;
    end else begin
      lcd_data  <= CODE_WHITE;
      lcd_valid <= 1'b0;
      case (state)
        INIT: begin
          if (idle_cnt == IW'(INIT_IDLE - 1)) state <= RUN;
          else                                idle_cnt <= idle_cnt + 1'b1;
        end
        RUN: begin
          if (!empty) begin
            lcd_data  <= head;
            lcd_valid <= 1'b1;
            code_cnt  <= cnt_next;
            if ((cnt_next & 6'(FRAME_LEN - 1)) == 6'd0) begin
              state   <= GAP;
              gap_cnt <= 4'(FRAME_GAP);
            end else if ((cnt_next & 6'(GROUP_LEN - 1)) == 6'd0) begin
              state   <= GAP;
              gap_cnt <= 4'(GROUP_GAP);
            end
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt - 4'd1;
          if (gap_cnt == 4'd1) state <= RUN;
        end
        default: state <= INIT;
      endcase
    end
  end

`ifdef FEED_UNDERFLOW_FLAG_EN
  logic issued;
  logic underflow;

  assign feed.Underflow = underflow;

  always_ff @(posedge LcdFeed_clk) begin
    if (LcdFeed_rst) begin
      issued    <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (pop) issued <= 1'b1;
      if ((state == RUN) && empty && issued) underflow <= 1'b1;
    end
  end
`endif

endmodule
